// File: rtl/stream_decoder.sv
// Streaming instruction decoder: headers plus optional multi-word or short
// sign-extended immediates in, one registered decoded bundle out.
module stream_decoder #(
  parameter int          DATA_W    = 64,
  parameter int          INST_W    = 32,
  parameter logic [11:0] ALU_LIMIT = 12'h100
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [INST_W-1:0] in_word,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [11:0]       opcode,
  output logic [3:0]        mode,
  output logic [5:0]        rsrc,
  output logic [5:0]        rdest,
  output logic [3:0]        flags,
  output logic [DATA_W-1:0] imm,
  output logic              imm_en,
  output logic [7:0]        alu_op,
  output logic              alu_en,
  output logic              mem_read,
  output logic              mem_write,
  output logic              reg_write,
  output logic              illegal
);

  localparam int NW = DATA_W / INST_W;
  localparam int CW = $clog2(NW) + 1;

  // state | meaning
  // S_HDR | waiting for an instruction header
  // S_IMM | collecting immediate words for the pending header
  typedef enum logic {S_HDR, S_IMM} state_t;

  state_t            state_q;
  logic [CW-1:0]     cnt_q, exp_q;
  logic              short_q;
  logic [INST_W-1:0] hdr_q;
  logic [DATA_W-1:0] acc_q;
  logic              out_valid_q;

  logic              out_free, last_word, accept, load;
  logic [INST_W-1:0] load_word;
  logic [DATA_W-1:0] acc_d, imm_d;
  logic [11:0]       opc_d;
  logic [7:0]        alu_op_d;
  logic              alu_en_d, mem_read_d, mem_write_d, reg_write_d, illegal_d;

  assign out_valid = out_valid_q;
  assign out_free  = !out_valid_q || out_ready;
  assign last_word = (cnt_q == exp_q - CW'(1));
  assign in_ready  = !flush && ((state_q == S_HDR) ? out_free : (last_word ? out_free : 1'b1));
  assign accept    = in_valid && in_ready;
  assign load      = accept && ((state_q == S_HDR) ? !in_word[0] : last_word);
  assign load_word = (state_q == S_HDR) ? in_word : hdr_q;

  always_comb begin
    acc_d = acc_q;
    for (int i = 0; i < NW; i++) begin
      if (cnt_q == CW'(i)) acc_d[i*INST_W +: INST_W] = in_word;
    end
    if (state_q == S_HDR) imm_d = '0;
    else if (short_q)     imm_d = DATA_W'($signed(in_word));
    else                  imm_d = acc_d;
  end

  always_comb begin
    opc_d       = load_word[31:20];
    alu_op_d    = '0;
    alu_en_d    = 1'b0;
    mem_read_d  = 1'b0;
    mem_write_d = 1'b0;
    reg_write_d = 1'b0;
    illegal_d   = 1'b0;
    if (opc_d < ALU_LIMIT) begin
      alu_en_d    = 1'b1;
      reg_write_d = 1'b1;
      alu_op_d    = opc_d[7:0];
    end else if (opc_d == 12'h100) begin
      mem_read_d  = 1'b1;
      reg_write_d = 1'b1;
    end else if (opc_d == 12'h101) begin
      mem_write_d = 1'b1;
    end else if (opc_d != 12'hFFF) begin
      illegal_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_HDR;
      cnt_q       <= '0;
      exp_q       <= '0;
      short_q     <= 1'b0;
      hdr_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
      opcode      <= '0;
      mode        <= '0;
      rsrc        <= '0;
      rdest       <= '0;
      flags       <= '0;
      imm         <= '0;
      imm_en      <= 1'b0;
      alu_op      <= '0;
      alu_en      <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      reg_write   <= 1'b0;
      illegal     <= 1'b0;
    end else if (flush) begin
      state_q     <= S_HDR;
      cnt_q       <= '0;
      acc_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (load) begin
        out_valid_q <= 1'b1;
        opcode      <= opc_d;
        mode        <= load_word[19:16];
        rsrc        <= load_word[15:10];
        rdest       <= load_word[9:4];
        flags       <= load_word[3:0];
        imm         <= imm_d;
        imm_en      <= (state_q == S_IMM);
        alu_op      <= alu_op_d;
        alu_en      <= alu_en_d;
        mem_read    <= mem_read_d;
        mem_write   <= mem_write_d;
        reg_write   <= reg_write_d;
        illegal     <= illegal_d;
      end else if (out_valid_q && out_ready) begin
        out_valid_q <= 1'b0;
      end
      case (state_q)
        S_HDR: if (accept) begin
          hdr_q   <= in_word;
          acc_q   <= '0;
          cnt_q   <= '0;
          short_q <= in_word[1];
          exp_q   <= in_word[1] ? CW'(1) : CW'(NW);
          if (in_word[0]) state_q <= S_IMM;
        end
        S_IMM: if (accept) begin
          if (last_word) begin
            state_q <= S_HDR;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= S_HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_stream_decoder.sv
// Bench for stream_decoder: a word-queue reference model checked every cycle,
// plus directed sequences with hand-computed expectations.
module tb_stream_decoder;

  localparam int DATA_W = 64;
  localparam int INST_W = 32;
  localparam int NW     = DATA_W / INST_W;
  localparam int BW     = 12 + 4 + 6 + 6 + 4 + DATA_W + 1 + 8 + 5;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, out_ready;
  logic [INST_W-1:0] in_word;
  logic              in_ready, out_valid, imm_en, alu_en, mem_read, mem_write, reg_write, illegal;
  logic [11:0]       opcode;
  logic [3:0]        mode, flags;
  logic [5:0]        rsrc, rdest;
  logic [DATA_W-1:0] imm;
  logic [7:0]        alu_op;
  logic [BW-1:0]     dut_bun;

  int errs = 0;
  int checks = 0;

  bit          m_ov, m_busy;
  int          m_need;
  logic [31:0] m_hdr;
  logic [31:0] m_words[$];
  logic [BW-1:0] m_bun;

  stream_decoder #(.DATA_W(DATA_W), .INST_W(INST_W), .ALU_LIMIT(12'h100)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_word(in_word), .in_valid(in_valid),
    .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
    .opcode(opcode), .mode(mode), .rsrc(rsrc), .rdest(rdest), .flags(flags),
    .imm(imm), .imm_en(imm_en), .alu_op(alu_op), .alu_en(alu_en),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write), .illegal(illegal)
  );

  assign dut_bun = {opcode, mode, rsrc, rdest, flags, imm, imm_en, alu_op,
                    alu_en, mem_read, mem_write, reg_write, illegal};

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] mk_bundle(input logic [31:0] h, input logic [DATA_W-1:0] iv, input bit ie);
    logic [11:0] op;
    logic [7:0]  aop;
    bit ae, mr, mw, rw, il;
    op = h[31:20];
    aop = 8'h00; ae = 0; mr = 0; mw = 0; rw = 0; il = 0;
    if (op < 12'h100) begin ae = 1; rw = 1; aop = op[7:0]; end
    else if (op == 12'h100) begin mr = 1; rw = 1; end
    else if (op == 12'h101) mw = 1;
    else if (op != 12'hFFF) il = 1;
    return {op, h[19:16], h[15:10], h[9:4], h[3:0], iv, ie, aop, ae, mr, mw, rw, il};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  // Called at a negedge: drive, compare, advance the model, move to next negedge.
  task automatic step(input bit v, input logic [31:0] w, input bit ordy, input bit fl, output bit rdy);
    bit exp_rdy, load;
    logic [BW-1:0] nb;
    logic [DATA_W-1:0] iv;
    in_valid = v; in_word = w; out_ready = ordy; flush = fl;
    #1;
    if (fl) exp_rdy = 0;
    else if (!m_busy) exp_rdy = !m_ov || ordy;
    else if (m_words.size() == m_need - 1) exp_rdy = !m_ov || ordy;
    else exp_rdy = 1;
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, m_ov);
    if (m_ov) chk("bundle", dut_bun, m_bun);
    rdy = in_ready;
    load = 0;
    nb = '0;
    if (fl) begin
      m_ov = 0; m_busy = 0; m_words.delete();
    end else begin
      if (v && exp_rdy) begin
        if (!m_busy) begin
          if (w[0]) begin
            m_busy = 1; m_hdr = w; m_need = w[1] ? 1 : NW; m_words.delete();
          end else begin
            nb = mk_bundle(w, '0, 0); load = 1;
          end
        end else begin
          m_words.push_back(w);
          if (m_words.size() == m_need) begin
            iv = '0;
            if (m_need == 1) iv = {{(DATA_W-32){m_words[0][31]}}, m_words[0]};
            else for (int i = 0; i < NW; i++) iv[32*i +: 32] = m_words[i];
            nb = mk_bundle(m_hdr, iv, 1); load = 1; m_busy = 0;
          end
        end
      end
      if (load) begin m_ov = 1; m_bun = nb; end
      else if (m_ov && ordy) m_ov = 0;
    end
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_word();
    logic [11:0] op;
    case ($urandom_range(0, 5))
      0, 1:    op = 12'($urandom_range(0, 255));
      2:       op = 12'h100;
      3:       op = 12'h101;
      4:       op = 12'hFFF;
      default: op = 12'($urandom);
    endcase
    return {op, 20'($urandom)};
  endfunction

  initial begin
    bit r;
    rst = 1; flush = 0; in_valid = 0; out_ready = 0; in_word = '0;
    m_ov = 0; m_busy = 0; m_need = 0; m_hdr = '0; m_bun = '0;
    @(negedge clk);
    chk("reset_bundle", dut_bun, '0);
    chk("reset_out_valid", out_valid, 0);
    rst = 0;

    // plain ALU op
    step(1, 32'h0030_4520, 1, 0, r);
    chk("alu_valid", out_valid, 1);
    chk("alu_opcode", opcode, 12'h003);
    chk("alu_aluop", alu_op, 8'h03);
    chk("alu_rsrc", rsrc, 6'h11);
    chk("alu_rdest", rdest, 6'h12);
    chk("alu_ctl", {alu_en, reg_write, imm_en, mem_read, mem_write, illegal}, 6'b110000);

    // LOAD with full-width immediate
    step(1, 32'h1000_0001, 1, 0, r);
    step(1, 32'hDEAD_BEEF, 1, 0, r);
    chk("load_no_early_valid", out_valid, 0);
    step(1, 32'h0123_4567, 1, 0, r);
    chk("load_valid", out_valid, 1);
    chk("load_imm", imm, 64'h0123_4567_DEAD_BEEF);
    chk("load_ctl", {mem_read, reg_write, imm_en, alu_en, mem_write, illegal}, 6'b111000);

    // STORE with short sign-extended immediate
    step(1, 32'h1010_0003, 1, 0, r);
    step(1, 32'h8000_0010, 1, 0, r);
    chk("short_valid", out_valid, 1);
    chk("short_imm", imm, 64'hFFFF_FFFF_8000_0010);
    chk("short_ctl", {mem_write, reg_write, mem_read, imm_en}, 4'b1001);
    step(0, '0, 1, 0, r);

    // backpressure with two ALU headers
    step(1, 32'h0050_5560, 0, 0, r);
    step(1, 32'h00A0_1230, 0, 0, r);
    chk("bp_second_blocked", r, 0);
    chk("bp_hold_opcode", opcode, 12'h005);
    step(1, 32'h00A0_1230, 1, 0, r);
    chk("bp_second_taken", r, 1);
    chk("bp_back_to_back", {out_valid, opcode}, {1'b1, 12'h00A});
    step(0, '0, 1, 0, r);

    // illegal opcode still consumes its immediate
    step(1, 32'h2000_0001, 1, 0, r);
    step(1, 32'h1111_1111, 1, 0, r);
    chk("ill_word1_taken", r, 1);
    step(1, 32'h2222_2222, 1, 0, r);
    chk("ill_word2_taken", r, 1);
    chk("ill_flags", {out_valid, illegal, alu_en, mem_read, mem_write, reg_write}, 6'b110000);
    chk("ill_imm", imm, 64'h2222_2222_1111_1111);
    step(1, 32'h0030_4520, 1, 0, r);
    chk("ill_next_hdr", {out_valid, illegal, alu_en, opcode}, {3'b101, 12'h003});

    // flush mid-immediate
    step(1, 32'h1000_0001, 1, 0, r);
    step(1, 32'hDEAD_BEEF, 1, 0, r);
    step(1, 32'h0123_4567, 1, 1, r);
    chk("flush_in_ready", r, 0);
    chk("flush_no_bundle", out_valid, 0);
    step(1, 32'h0030_4520, 1, 0, r);
    chk("flush_next_hdr", {out_valid, imm_en, opcode}, {2'b10, 12'h003});

    // asynchronous reset inside S_IMM
    step(1, 32'h1000_0001, 1, 0, r);
    step(1, 32'hDEAD_BEEF, 0, 0, r);
    in_valid = 0;
    #2 rst = 1;
    #1;
    chk("arst_bundle", dut_bun, '0);
    chk("arst_out_valid", out_valid, 0);
    m_ov = 0; m_busy = 0; m_words.delete();
    @(negedge clk);
    rst = 0;
    step(1, 32'h0030_4520, 1, 0, r);
    chk("arst_next_hdr", {out_valid, imm_en, opcode}, {2'b10, 12'h003});

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 7, rand_word(), $urandom_range(0, 9) < 6,
           $urandom_range(0, 39) == 0, r);
    end
    step(0, '0, 1, 0, r);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
